// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the ECC-protected SRAM controller.
//   DW/PW/CWW   data, check and codeword widths
//   H_ROW       parity-check row masks; check bit k = ^(data & H_ROW[k])
//   state_t     controller FSM states (ST_WB exists only with ECC_WRITEBACK_EN)
//   ERR_*       response error codes
//   h_col()     extracts the 7-bit H column for one data bit
package ecc_pkg;

  localparam int DW  = 32;
  localparam int PW  = 7;
  localparam int CWW = 40;

  // Columns are the first 32 weight-3 7-bit vectors in ascending order
  // (7'h07, 7'h0B, 7'h0D, ... 7'h62), so data bit 0 has column 7'h07 and
  // data bit 1 has column 7'h0B.  These masks are that matrix read by rows.
  localparam logic [DW-1:0] H_ROW [PW] = '{
    32'h44B1_2CB7,
    32'h8952_555B,
    32'h1264_9A6D,
    32'h2388_E38E,
    32'h3C0F_03F0,
    32'hC00F_FC00,
    32'hFFF0_0000
  };

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CHK  = 3'd3
`ifdef ECC_WRITEBACK_EN
    , ST_WB = 3'd4
`endif
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_CORR   = 2'b01;
  localparam logic [1:0] ERR_UNCORR = 2'b10;

  function automatic logic [PW-1:0] h_col(input int j);
    logic [PW-1:0] col;
    for (int k = 0; k < PW; k++) begin
      col[k] = H_ROW[k][j];
    end
    return col;
  endfunction

endpackage

// File: rtl/ecc_syndrome_gen.sv
// ecc_syndrome_gen: combinational row-parity / syndrome generator.
//   data [31:0]  data word
//   chk  [6:0]   stored check bits (tie to 0 to obtain encoder check bits)
//   syn  [6:0]   row parities of data XOR chk
module ecc_syndrome_gen
  import ecc_pkg::*;
(
  input  logic [DW-1:0] data,
  input  logic [PW-1:0] chk,
  output logic [PW-1:0] syn
);

  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_row
      assign syn[gi] = (^(data & H_ROW[gi])) ^ chk[gi];
    end
  endgenerate

endmodule

// File: rtl/ecc_sram_ctrl.sv
// ecc_sram_ctrl: host/scrubber sequencer for a single-port ECC SRAM.
//   Host side : req_valid/req_ready/req_we/req_addr/req_wdata in,
//               rsp_valid/rsp_rdata/rsp_err out (read responses only).
//   SRAM side : sram_en/sram_we/sram_addr/sram_wdata out, sram_rdata in
//               (read data valid the cycle after the read strobe).
//   Scrubber  : scrub_en enables a periodic background read of the array.
//   Status    : corr_cnt/uncorr_cnt saturating error counters.
// Build option: define ECC_WRITEBACK_EN to write corrected words back to
// the SRAM after a correctable error (adds the WB state).
module ecc_sram_ctrl
  import ecc_pkg::*;
#(
  parameter int AW           = 8,
  parameter int DEPTH        = 256,
  parameter int SCRUB_PERIOD = 1024,
  parameter int CNTW         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  output logic             rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic [1:0]       rsp_err,
  output logic             sram_en,
  output logic             sram_we,
  output logic [AW-1:0]    sram_addr,
  output logic [CWW-1:0]   sram_wdata,
  input  logic [CWW-1:0]   sram_rdata,
  input  logic             scrub_en,
  output logic [CNTW-1:0]  corr_cnt,
  output logic [CNTW-1:0]  uncorr_cnt
);

  localparam int TW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            scrub_q, scrub_d;        // access in flight belongs to the scrubber
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_err_q, rsp_err_d;
  logic [CNTW-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNTW-1:0] uncorr_cnt_q, uncorr_cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            scrub_pend_q, scrub_pend_d;
  logic [AW-1:0]   scrub_addr_q, scrub_addr_d;

  // Encoder works on data_q, which holds host write data in WR and the
  // corrected word in WB, so one instance covers both writes.
  logic [PW-1:0] enc_chk;
  logic [PW-1:0] rd_syn;

  ecc_syndrome_gen u_enc (
    .data (data_q),
    .chk  ({PW{1'b0}}),
    .syn  (enc_chk)
  );

  ecc_syndrome_gen u_chk (
    .data (sram_rdata[DW-1:0]),
    .chk  (sram_rdata[CWW-2:DW]),
    .syn  (rd_syn)
  );

  logic unused_rdata_msb;
  assign unused_rdata_msb = sram_rdata[CWW-1];

  // Syndrome classification
  logic [DW-1:0] flip_mask;
  logic          syn_zero, syn_chk_bit, is_corr, is_uncorr;
  logic [1:0]    rd_err;
  logic [DW-1:0] rd_fixed;

  generate
    for (genvar gi = 0; gi < DW; gi++) begin : g_col
      assign flip_mask[gi] = (rd_syn == h_col(gi));
    end
  endgenerate

  assign syn_zero    = (rd_syn == '0);
  // Single set bit: the error sits in a check bit, data is already right.
  assign syn_chk_bit = !syn_zero && ((rd_syn & (rd_syn - PW'(1))) == '0);
  assign is_corr     = (|flip_mask) || syn_chk_bit;
  assign is_uncorr   = !syn_zero && !is_corr;
  assign rd_err      = syn_zero ? ERR_NONE : (is_corr ? ERR_CORR : ERR_UNCORR);
  // No column matches for an uncorrectable syndrome, so this is the raw data.
  assign rd_fixed    = sram_rdata[DW-1:0] ^ flip_mask;

  logic tmr_expire, scrub_done;
  assign tmr_expire = scrub_en && (tmr_q == TW'(SCRUB_PERIOD - 1));
  assign scrub_done = (state_q == ST_CHK) && scrub_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      scrub_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= ERR_NONE;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      tmr_q        <= '0;
      scrub_pend_q <= 1'b0;
      scrub_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      scrub_q      <= scrub_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      tmr_q        <= tmr_d;
      scrub_pend_q <= scrub_pend_d;
      scrub_addr_q <= scrub_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = req_we ? ST_WR : ST_RD;
        end else if (scrub_pend_q) begin
          state_d = ST_RD;
        end
      end
      ST_WR:  state_d = ST_IDLE;
      ST_RD:  state_d = ST_CHK;
`ifdef ECC_WRITEBACK_EN
      ST_CHK: state_d = is_corr ? ST_WB : ST_IDLE;
      ST_WB:  state_d = ST_IDLE;
`else
      ST_CHK: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath, scrub timer and counters
  always_comb begin
    addr_d       = addr_q;
    data_d       = data_q;
    scrub_d      = scrub_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    scrub_addr_d = scrub_addr_q;

    // A request that expires while one is pending simply stays single;
    // an expiry in the same cycle a scrub completes re-arms the request.
    if (!scrub_en) begin
      tmr_d = '0;
    end else if (tmr_expire) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TW'(1);
    end
    scrub_pend_d = scrub_en && (tmr_expire || (scrub_pend_q && !scrub_done));

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_wdata;
          scrub_d = 1'b0;
        end else if (scrub_pend_q) begin
          addr_d  = scrub_addr_q;
          scrub_d = 1'b1;
        end
      end
      ST_CHK: begin
        data_d = rd_fixed;
        if (is_corr && (corr_cnt_q != '1)) begin
          corr_cnt_d = corr_cnt_q + CNTW'(1);
        end
        if (is_uncorr && (uncorr_cnt_q != '1)) begin
          uncorr_cnt_d = uncorr_cnt_q + CNTW'(1);
        end
        if (scrub_q) begin
          scrub_addr_d = (scrub_addr_q == AW'(DEPTH - 1)) ? '0 : scrub_addr_q + AW'(1);
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_fixed;
          rsp_err_d   = rd_err;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = 1'b0;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    unique case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_WR: begin
        sram_en = 1'b1;
        sram_we = 1'b1;
      end
      ST_RD: sram_en = 1'b1;
`ifdef ECC_WRITEBACK_EN
      ST_WB: begin
        sram_en = 1'b1;
        sram_we = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = {1'b0, enc_chk, data_q};
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc_sram_ctrl.sv
// tb_ecc_sram_ctrl: directed bench for ecc_sram_ctrl with a behavioural
// single-port SRAM, a backdoor preload port and an access log.
module tb_ecc_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        sram_en;
  logic        sram_we;
  logic [7:0]  sram_addr;
  logic [39:0] sram_wdata;
  logic [39:0] sram_rdata = '0;
  logic        scrub_en = 1'b0;
  logic [1:0]  corr_cnt;
  logic [1:0]  uncorr_cnt;

  always #5 clk = ~clk;

  ecc_sram_ctrl #(.AW(8), .DEPTH(4), .SCRUB_PERIOD(8), .CNTW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .scrub_en   (scrub_en),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  // ---------------- SRAM model with backdoor and access log ----------------
  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [39:0] data;
  } ev_t;

  ev_t         ev_q[$];
  logic [39:0] mem [256];
  logic        bd_clr = 1'b1;
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = '0;
  logic [39:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (sram_en) begin
      ev_q.push_back('{we: sram_we, addr: sram_addr, data: sram_wdata});
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Reference check bits: enumerate weight-3 columns and XOR the columns
  // of every set data bit.
  function automatic logic [6:0] model_chk(input logic [31:0] d);
    logic [6:0] acc;
    int j;
    acc = '0;
    j = 0;
    for (int v = 0; v < 128; v++) begin
      if (($countones(v[6:0]) == 3) && (j < 32)) begin
        if (d[j]) acc ^= v[6:0];
        j++;
      end
    end
    return acc;
  endfunction

  function automatic int count_reads(input int from);
    int n;
    n = 0;
    for (int i = from; i < ev_q.size(); i++) if (!ev_q[i].we) n++;
    return n;
  endfunction

  function automatic int count_writes(input int from);
    int n;
    n = 0;
    for (int i = from; i < ev_q.size(); i++) if (ev_q[i].we) n++;
    return n;
  endfunction

  function automatic logic [7:0] read_addr(input int from, input int k);
    int n;
    n = 0;
    for (int i = from; i < ev_q.size(); i++) begin
      if (!ev_q[i].we) begin
        if (n == k) return ev_q[i].addr;
        n++;
      end
    end
    return 8'hFF;
  endfunction

  // ---------------- stimulus helpers ----------------
  logic        r_seen;
  int          r_lat;
  logic [31:0] r_data;
  logic [1:0]  r_err;
  logic        r_en, r_we;
  logic [7:0]  r_addr;
  logic [39:0] r_wdata;

  task automatic preload(input logic [7:0] a, input logic [39:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    chk_eq("wr_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    chk_eq("wr_sram_en", 64'(sram_en), 64'(1));
    chk_eq("wr_sram_we", 64'(sram_we), 64'(1));
    chk_eq("wr_addr", 64'(sram_addr), 64'(a));
    chk_eq("wr_codeword", 64'(sram_wdata), 64'({1'b0, model_chk(d), d}));
    chk_eq("wr_busy", 64'(req_ready), 64'(0));
  endtask

  // Captures the response and the SRAM outputs in the response cycle.
  task automatic host_read(input logic [7:0] a);
    @(negedge clk);
    chk_eq("rd_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    r_seen = 1'b0; r_lat = 0;
    for (int i = 1; i < 10; i++) begin
      if (rsp_valid) begin
        r_seen = 1'b1; r_lat = i;
        r_data = rsp_rdata; r_err = rsp_err;
        r_en = sram_en; r_we = sram_we; r_addr = sram_addr; r_wdata = sram_wdata;
        break;
      end
      @(negedge clk);
    end
    chk_eq("rd_rsp_seen", 64'(r_seen), 64'(1));
  endtask

  task automatic check_wb(input string tag, input logic [7:0] a, input logic [39:0] cw);
`ifdef ECC_WRITEBACK_EN
    chk_eq({tag, "_wb_en"}, 64'(r_en && r_we), 64'(1));
    chk_eq({tag, "_wb_addr"}, 64'(r_addr), 64'(a));
    chk_eq({tag, "_wb_data"}, 64'(r_wdata), 64'(cw));
`else
    chk_eq({tag, "_no_wb"}, 64'(r_en), 64'(0));
`endif
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] exp_walk [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
  int         idx;
  logic       done;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; bd_clr = 1'b0;
    chk_eq("rst_ready", 64'(req_ready), 64'(1));
    chk_eq("rst_sram_en", 64'(sram_en), 64'(0));
    chk_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk_eq("rst_corr_cnt", 64'(corr_cnt), 64'(0));
    chk_eq("rst_uncorr_cnt", 64'(uncorr_cnt), 64'(0));

    // Write then read back
    host_write(8'd5, 32'hDEAD_BEEF);
    host_read(8'd5);
    chk_eq("rd5_latency", 64'(r_lat), 64'(3));
    chk_eq("rd5_data", 64'(r_data), 64'(32'hDEAD_BEEF));
    chk_eq("rd5_err", 64'(r_err), 64'(2'b00));

    // Data bit 0 flipped: syndrome 7'h07
    preload(8'd3, 40'h00_0000_0001);
    host_read(8'd3);
    chk_eq("rd3_data", 64'(r_data), 64'(0));
    chk_eq("rd3_err", 64'(r_err), 64'(2'b01));
    chk_eq("rd3_corr_cnt", 64'(corr_cnt), 64'(1));
    check_wb("rd3", 8'd3, 40'h0);

    // Data bits 0 and 1 flipped: syndrome 7'h0C, uncorrectable
    preload(8'd4, 40'h00_0000_0003);
    host_read(8'd4);
    chk_eq("rd4_data_raw", 64'(r_data), 64'(32'h3));
    chk_eq("rd4_err", 64'(r_err), 64'(2'b10));
    chk_eq("rd4_uncorr_cnt", 64'(uncorr_cnt), 64'(1));
    chk_eq("rd4_no_write", 64'(r_en), 64'(0));

    // Check bit 0 flipped
    preload(8'd6, 40'h01_0000_0000);
    host_read(8'd6);
    chk_eq("rd6_data", 64'(r_data), 64'(0));
    chk_eq("rd6_err", 64'(r_err), 64'(2'b01));
    chk_eq("rd6_corr_cnt", 64'(corr_cnt), 64'(2));
    check_wb("rd6", 8'd6, 40'h0);

    // Highest data bit flipped on a nonzero word
    preload(8'd7, {1'b0, model_chk(32'h1234_5678), 32'h1234_5678 ^ 32'h8000_0000});
    host_read(8'd7);
    chk_eq("rd7_data", 64'(r_data), 64'(32'h1234_5678));
    chk_eq("rd7_err", 64'(r_err), 64'(2'b01));
    chk_eq("rd7_corr_cnt", 64'(corr_cnt), 64'(3));
    check_wb("rd7", 8'd7, {1'b0, model_chk(32'h1234_5678), 32'h1234_5678});

    // Bit 39 must be ignored
    preload(8'd8, {1'b1, model_chk(32'hA5A5_A5A5), 32'hA5A5_A5A5});
    host_read(8'd8);
    chk_eq("rd8_data", 64'(r_data), 64'(32'hA5A5_A5A5));
    chk_eq("rd8_err", 64'(r_err), 64'(2'b00));

    // Check bit 4 flipped; counter already at all-ones must hold
    preload(8'd9, {1'b0, model_chk(32'h0F0F_0F0F) ^ 7'h10, 32'h0F0F_0F0F});
    host_read(8'd9);
    chk_eq("rd9_data", 64'(r_data), 64'(32'h0F0F_0F0F));
    chk_eq("rd9_err", 64'(r_err), 64'(2'b01));
    chk_eq("rd9_corr_sat", 64'(corr_cnt), 64'(3));

    // Weight-3 syndrome that is not a data column: uncorrectable
    preload(8'd10, 40'h70_0000_0000);
    host_read(8'd10);
    chk_eq("rd10_err", 64'(r_err), 64'(2'b10));
    chk_eq("rd10_uncorr_cnt", 64'(uncorr_cnt), 64'(2));

    // Scrub walk over DEPTH=4 with one correctable word at addr 1
    preload(8'd0, 40'h0);
    preload(8'd1, 40'h00_0000_0002);
    preload(8'd2, 40'h0);
    preload(8'd3, 40'h0);
    idx = ev_q.size();
    @(negedge clk);
    scrub_en = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (count_reads(idx) >= 5) begin
        done = 1'b1;
        break;
      end
    end
    scrub_en = 1'b0;
    chk_eq("scrub_walk_done", 64'(done), 64'(1));
    for (int k = 0; k < 5; k++) begin
      chk_eq($sformatf("scrub_rd%0d_addr", k), 64'(read_addr(idx, k)), 64'(exp_walk[k]));
    end
`ifdef ECC_WRITEBACK_EN
    chk_eq("scrub_wb_count", 64'(count_writes(idx)), 64'(1));
    chk_eq("scrub_wb_mem1", 64'(mem[1]), 64'(40'h0));
`else
    chk_eq("scrub_no_writes", 64'(count_writes(idx)), 64'(0));
    chk_eq("scrub_mem1_kept", 64'(mem[1]), 64'(40'h00_0000_0002));
`endif

    // Host request arriving in the cycle scrub_pend rises is served first
    repeat (3) @(negedge clk);
    idx = ev_q.size();
    @(negedge clk);
    scrub_en = 1'b1;
    repeat (8) @(posedge clk);
    host_read(8'd5);
    chk_eq("prio_host_data", 64'(r_data), 64'(32'hDEAD_BEEF));
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (count_reads(idx) >= 2) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    scrub_en = 1'b0;
    chk_eq("prio_two_reads", 64'(done), 64'(1));
    chk_eq("prio_first_host", 64'(read_addr(idx, 0)), 64'(8'd5));
    chk_eq("prio_then_scrub", 64'(read_addr(idx, 1)), 64'(8'd1));

    // Reset in the middle of a correcting read
    repeat (3) @(negedge clk);
    preload(8'd3, 40'h00_0000_0001);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
`ifdef ECC_WRITEBACK_EN
    @(negedge clk);
    chk_eq("pre_rst_in_wb", 64'(sram_en && sram_we), 64'(1));
`else
    chk_eq("pre_rst_busy", 64'(req_ready), 64'(0));
`endif
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_eq("mid_rst_sram_en", 64'(sram_en), 64'(0));
    chk_eq("mid_rst_ready", 64'(req_ready), 64'(1));
    chk_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk_eq("mid_rst_corr_cnt", 64'(corr_cnt), 64'(0));
    chk_eq("mid_rst_uncorr_cnt", 64'(uncorr_cnt), 64'(0));
    rst_n = 1'b1;
    idx = ev_q.size();
    scrub_en = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (count_reads(idx) >= 1) begin
        done = 1'b1;
        break;
      end
    end
    scrub_en = 1'b0;
    chk_eq("post_rst_scrub_seen", 64'(done), 64'(1));
    chk_eq("post_rst_scrub_addr", 64'(read_addr(idx, 0)), 64'(8'd0));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
